alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//   Shares one combinational 64-bit ALU between NREQ requesters. Arbitrates
//   round-robin, registers the winner's operands onto the ALU inputs, captures
//   the ALU result and returns it to the winner over a valid/ready handshake.
//   Sits between the issue logic and the ALU in the multi-requester datapath.
// PARAMETERS
//   WIDTH  64  operand/result width; must match the ALU
//   NREQ   2   number of requesters, 2..8
// PORTS
//   clk         in   1           system clock, rising edge
//   rst         in   1           asynchronous, active-high reset
//   req_valid   in   NREQ        requester i has an operation pending
//   req_ready   out  NREQ        one-hot; request i accepted this cycle
//   req_ctrl    in   4*NREQ      ALU op code of requester i, slice [4i+3:4i]
//   req_a       in   WIDTH*NREQ  operand A of requester i
//   req_b       in   WIDTH*NREQ  operand B of requester i
//   resp_valid  out  NREQ        one-hot; result for requester i available
//   resp_ready  in   NREQ        requester i takes the result
//   resp_data   out  WIDTH       result; meaningful only while resp_valid != 0
//   resp_zero   out  1           resp_data == 0
//   alu_ctrl    out  4           registered op code to the ALU
//   alu_a       out  WIDTH       registered operand A to the ALU
//   alu_b       out  WIDTH       registered operand B to the ALU
//   alu_out     in   WIDTH       combinational ALU result
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_data=0,
//     resp_zero=0, alu_ctrl=0, alu_a=0, alu_b=0. A reset in any state drops
//     the operation in flight; no response is issued for it.
//   FSM IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE: if any req_valid, grant the first valid index at or above rr_ptr,
//     wrapping modulo NREQ. req_ready[g]=1 for exactly this cycle; latch
//     req_ctrl/a/b[g] into alu_ctrl/a/b; store g; go to ISSUE. No valid: stay.
//     req_ready is combinational from req_valid and rr_ptr; zero outside IDLE.
//   ISSUE: ALU evaluates the registered operands; at the clock edge capture
//     alu_out into resp_data, set resp_zero=(alu_out==0), go to RESP.
//   RESP: resp_valid[g]=1. resp_data/resp_zero held stable. On resp_ready[g]:
//     rr_ptr=(g+1) mod NREQ, resp_valid=0, go to IDLE. resp_ready[j], j!=g,
//     ignored.
//   Latency: accept at edge T -> resp_valid high from T+2. Peak throughput:
//     one op per 3 cycles (resp_ready tied high).
//   Ops are not filtered; unsupported codes pass through and return the
//     ALU's output (0 for undefined codes). Arithmetic wraps modulo 2^WIDTH.
//   Requester rule: req_valid and operands hold until req_ready; dropping
//     them earlier is a protocol violation (behaviour undefined).
//   A requester whose request arrives while another is being served waits;
//     a requester is never granted twice while another valid requester waits.
//   alu_ctrl/a/b keep the last issued op after RESP (not cleared).
// TESTING
//   1 Req0 ADD a=5 b=7, resp_ready=1 -> req_ready[0] at T, resp_valid[0]
//     at T+2, resp_data=12, resp_zero=0, back in IDLE at T+3.
//   2 SUB a=0 b=1 -> resp_data=64'hFFFF_FFFF_FFFF_FFFF; NOR a=b=all-ones
//     -> resp_data=0, resp_zero=1.
//   3 Req0 and Req1 valid continuously -> grants 0,1,0,1; each response
//     carries its own requester's result on the matching resp_valid bit.
//   4 resp_ready held low 10 cycles in RESP -> resp_valid/resp_data stable,
//     req_ready stays 0 though req_valid high; release -> next grant 1 cycle
//     after the handshake.
//   5 rst pulsed during ISSUE and during RESP (asynchronously, mid-cycle)
//     -> all outputs 0 immediately, no response, next grant goes to req0.
//   6 Undefined code 4'd4 with a=3 b=3 -> accepted normally, resp_data=0,
//     resp_zero=1.

Source files
------------

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//
// Shares one external combinational ALU between NREQ requesters. A round-robin
// arbiter picks one pending request, the winner's op code and operands are
// registered onto the ALU inputs, the ALU result is captured one cycle later,
// and the result is returned to the winner over a valid/ready handshake.
//
// Operation sequence (one operation in flight at a time):
//   IDLE  -> grant a requester, latch its operands     -> ISSUE
//   ISSUE -> ALU evaluates, capture alu_out            -> RESP
//   RESP  -> hold result until the winner takes it     -> IDLE
// An accept in the IDLE cycle T gives resp_valid from cycle T+2. With
// resp_ready tied high, the peak rate is one operation every three cycles.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high for the same requester index. The request side must hold req_valid
//   and its operands stable until it sees req_ready. The response side holds
//   resp_valid, resp_data and resp_zero stable until resp_ready is seen for
//   the granted index; ready bits for any other index are ignored.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset; drops any op in flight
//   req_valid   [NREQ]        requester i has an operation pending
//   req_ready   [NREQ]        one-hot; request i accepted this cycle
//   req_ctrl    [4*NREQ]      op code of requester i, slice [4i+3:4i]
//   req_a       [WIDTH*NREQ]  operand A of requester i
//   req_b       [WIDTH*NREQ]  operand B of requester i
//   resp_valid  [NREQ]        one-hot; result for requester i available
//   resp_ready  [NREQ]        requester i takes the result
//   resp_data   [WIDTH]       result, meaningful while resp_valid != 0
//   resp_zero   1             resp_data == 0
//   alu_ctrl    [4]           registered op code to the ALU
//   alu_a       [WIDTH]       registered operand A to the ALU
//   alu_b       [WIDTH]       registered operand B to the ALU
//   alu_out     [WIDTH]       combinational ALU result
// -----------------------------------------------------------------------------
module alu_share_arb #(
   parameter int WIDTH = 64,
   parameter int NREQ  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [4*NREQ-1:0]       req_ctrl,
   input  logic [WIDTH*NREQ-1:0]   req_a,
   input  logic [WIDTH*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]         resp_valid,
   input  logic [NREQ-1:0]         resp_ready,
   output logic [WIDTH-1:0]        resp_data,
   output logic                    resp_zero,
   output logic [3:0]              alu_ctrl,
   output logic [WIDTH-1:0]        alu_a,
   output logic [WIDTH-1:0]        alu_b,
   input  logic [WIDTH-1:0]        alu_out
);

   // Index width for requester numbers; at least one bit.
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic [NREQ-1:0] ONE_BIT = {{(NREQ-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [PW-1:0]    rr_ptr;      // first index searched in the next arbitration
   logic [PW-1:0]    gnt_q;       // requester owning the operation in flight

   logic             any_valid;
   logic [PW-1:0]    grant_idx;
   logic [3:0]       sel_ctrl;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [PW-1:0]    rr_next;

   // --------------------------------------------------------------------------
   // Round-robin search: first valid index at or above rr_ptr, wrapping modulo
   // NREQ. The loop runs from the farthest offset down to offset 0 so that the
   // nearest valid requester is the last one written and therefore wins.
   // NREQ need not be a power of two, so the wrap is an explicit subtract.
   // --------------------------------------------------------------------------
   always_comb begin
      any_valid = 1'b0;
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int s;
         s = int'(rr_ptr) + k;
         if (s >= NREQ) begin
            s = s - NREQ;
         end
         if (req_valid[PW'(s)]) begin
            any_valid = 1'b1;
            grant_idx = PW'(s);
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_ctrl = '0;
      sel_a    = '0;
      sel_b    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == PW'(i)) begin
            sel_ctrl = req_ctrl[i*4 +: 4];
            sel_a    = req_a[i*WIDTH +: WIDTH];
            sel_b    = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer moves to just past the requester that completed, so a requester
   // cannot be granted twice while another valid requester is waiting.
   assign rr_next = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);

   // req_ready is only offered in IDLE. It is also forced low while rst is
   // high, because a grant offered during reset would never be taken.
   always_comb begin
      req_ready = '0;
      if (!rst && state == S_IDLE && any_valid) begin
         req_ready = ONE_BIT << grant_idx;
      end
   end

   // State is cleared asynchronously, so resp_valid drops the moment rst rises.
   always_comb begin
      resp_valid = '0;
      if (state == S_RESP) begin
         resp_valid = ONE_BIT << gnt_q;
      end
   end

   // --------------------------------------------------------------------------
   // Sequencer. alu_ctrl/a/b keep the last issued op after RESP; they are only
   // rewritten by the next grant. resp_data/resp_zero likewise hold their last
   // captured value until the next ISSUE.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         gnt_q     <= '0;
         resp_data <= '0;
         resp_zero <= 1'b0;
         alu_ctrl  <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  alu_ctrl <= sel_ctrl;
                  alu_a    <= sel_a;
                  alu_b    <= sel_b;
                  gnt_q    <= grant_idx;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               resp_data <= alu_out;
               resp_zero <= (alu_out == '0);
               state     <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready[gnt_q]) begin
                  rr_ptr <= rr_next;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//
// Bench for alu_share_arb with WIDTH=64, NREQ=3 (three requesters so the
// round-robin wrap is not a power of two). The bench supplies the ALU itself:
//   0 ADD, 1 SUB, 2 AND, 3 OR, 5 XOR, 6 NOR, 7 SLL by b[5:0], others -> 0.
// A transaction-level model (pending operation, its owner, cycles since
// accept, round-robin pointer) predicts every output on every falling edge.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

   localparam int WIDTH = 64;
   localparam int NREQ  = 3;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   initial forever #5 clk = ~clk;

   // ---------------------------------------------------------------- DUT wiring
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [4*NREQ-1:0]     req_ctrl;
   logic [WIDTH*NREQ-1:0] req_a;
   logic [WIDTH*NREQ-1:0] req_b;
   logic [NREQ-1:0]       resp_valid;
   logic [NREQ-1:0]       resp_ready = '0;
   logic [WIDTH-1:0]      resp_data;
   logic                  resp_zero;
   logic [3:0]            alu_ctrl;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [WIDTH-1:0]      alu_out;

   logic [3:0]       ctrl [NREQ];
   logic [WIDTH-1:0] opa  [NREQ];
   logic [WIDTH-1:0] opb  [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_ctrl[i*4 +: 4]       = ctrl[i];
         req_a[i*WIDTH +: WIDTH]  = opa[i];
         req_b[i*WIDTH +: WIDTH]  = opb[i];
      end
   end

   function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [5:0] sh;
      sh = b[5:0];
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd5:    return a ^ b;
         4'd6:    return ~(a | b);
         4'd7:    return a << sh;
         default: return '0;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_ctrl, alu_a, alu_b);

   alu_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_ctrl   (req_ctrl),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_zero  (resp_zero),
      .alu_ctrl   (alu_ctrl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_out    (alu_out)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   bit               m_busy  = 1'b0;
   int               m_owner = 0;
   int               m_age   = 0;
   int               m_rr    = 0;
   logic [3:0]       m_ctrl  = '0;
   logic [WIDTH-1:0] m_a     = '0;
   logic [WIDTH-1:0] m_b     = '0;
   logic [WIDTH-1:0] m_res   = '0;
   logic [WIDTH-1:0] exp_q[$];          // results owed, oldest first
   logic [NREQ-1:0]  acc_mask = '0;     // requests the model says are taken at the next edge

   // Compare every output against the model, then advance the model to the
   // state it will be in after the coming rising edge.
   task automatic model_step();
      logic [NREQ-1:0] er;
      logic [NREQ-1:0] ev;
      int g;
      acc_mask = '0;
      if (rst) begin
         chk("rst_req_ready",  64'(req_ready), 64'd0);
         chk("rst_resp_valid", 64'(resp_valid), 64'd0);
         chk("rst_resp_data",  resp_data, 64'd0);
         chk("rst_resp_zero",  64'(resp_zero), 64'd0);
         chk("rst_alu_ctrl",   64'(alu_ctrl), 64'd0);
         chk("rst_alu_a",      alu_a, 64'd0);
         chk("rst_alu_b",      alu_b, 64'd0);
         m_busy = 1'b0; m_rr = 0; m_age = 0;
         m_ctrl = '0; m_a = '0; m_b = '0;
         exp_q.delete();
         return;
      end
      g  = -1;
      er = '0;
      if (!m_busy) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
         end
      end
      if (g >= 0) er[g] = 1'b1;
      ev = '0;
      if (m_busy && m_age >= 1) ev[m_owner] = 1'b1;

      chk("req_ready",  64'(req_ready), 64'(er));
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      if (ev != '0 && exp_q.size() > 0) begin
         chk("resp_data", resp_data, exp_q[0]);
         chk("resp_zero", 64'(resp_zero), 64'(exp_q[0] == '0));
      end
      chk("alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
      chk("alu_a",    alu_a, m_a);
      chk("alu_b",    alu_b, m_b);

      if (g >= 0) begin
         m_busy  = 1'b1;
         m_owner = g;
         m_age   = 0;
         m_ctrl  = ctrl[g];
         m_a     = opa[g];
         m_b     = opb[g];
         m_res   = alu_fn(ctrl[g], opa[g], opb[g]);
         exp_q.push_back(m_res);
         acc_mask = er;
      end else if (m_busy) begin
         if (m_age >= 1 && resp_ready[m_owner]) begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % NREQ;
            void'(exp_q.pop_front());
         end else begin
            m_age++;
         end
      end
   endtask

   // ---------------------------------------------------------------- driver tasks
   task automatic to_neg();
      @(negedge clk);
      model_step();
   endtask

   task automatic to_drive();
      @(posedge clk);
      #2;
   endtask

   task automatic new_ops(input int i);
      ctrl[i] = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
         0:       opa[i] = '0;
         1:       opa[i] = '1;
         default: opa[i] = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
         0:       opb[i] = '0;
         1:       opb[i] = '1;
         default: opb[i] = {$urandom, $urandom};
      endcase
   endtask

   // Single request with resp_ready high; literal expectations on the timing.
   // On return the bench is in the cycle right after the handshake (T+3).
   task automatic issue_one(input int idx, input logic [3:0] op,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp_data, input bit exp_zero);
      logic [NREQ-1:0] bit_i;
      bit_i = '0;
      bit_i[idx] = 1'b1;
      ctrl[idx] = op; opa[idx] = a; opb[idx] = b;
      req_valid = bit_i;
      resp_ready = '1;
      to_neg();
      chk("lit_accept", 64'(req_ready), 64'(bit_i));
      to_drive();
      req_valid = '0;
      to_neg();
      chk("lit_issue_no_resp", 64'(resp_valid), 64'd0);
      to_drive();
      to_neg();
      chk("lit_resp_valid", 64'(resp_valid), 64'(bit_i));
      chk("lit_resp_data",  resp_data, exp_data);
      chk("lit_resp_zero",  64'(resp_zero), 64'(exp_zero));
      to_drive();
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      resp_ready = '1;
      while ((req_valid != '0 || m_busy) && cyc < 50) begin
         to_neg();
         to_drive();
         req_valid = req_valid & ~acc_mask;
         cyc++;
      end
      chk("drain_timeout", 64'(req_valid != '0 || m_busy), 64'd0);
   endtask

   task automatic assert_rst_mid_cycle();
      #1 rst = 1'b1;
      #1;
      chk("async_req_ready",  64'(req_ready), 64'd0);
      chk("async_resp_valid", 64'(resp_valid), 64'd0);
      chk("async_resp_data",  resp_data, 64'd0);
      chk("async_alu_ctrl",   64'(alu_ctrl), 64'd0);
      chk("async_alu_a",      alu_a, 64'd0);
   endtask

   // ---------------------------------------------------------------- test body
   initial begin
      int gseq[$];
      int g;
      int other;

      for (int i = 0; i < NREQ; i++) begin
         ctrl[i] = '0; opa[i] = '0; opb[i] = '0;
      end

      // Reset state.
      to_neg();
      to_drive();
      to_neg();
      to_drive();
      rst = 1'b0;

      // Basic ops, wrap, NOR to zero, undefined code.
      issue_one(0, 4'd0, 64'd5, 64'd7, 64'd12, 1'b0);
      issue_one(1, 4'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      issue_one(2, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      issue_one(0, 4'd4, 64'd3, 64'd3, 64'd0, 1'b1);
      issue_one(1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);

      // Two requesters valid continuously: grants alternate 0,1,0,1.
      new_ops(0); new_ops(1);
      req_valid = 3'b011;
      resp_ready = '1;
      for (int cyc = 0; cyc < 20 && gseq.size() < 4; cyc++) begin
         to_neg();
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) gseq.push_back(i);
         to_drive();
         for (int i = 0; i < NREQ; i++) if (acc_mask[i]) new_ops(i);
      end
      chk("alt_grant_count", 64'(gseq.size()), 64'd4);
      for (int k = 0; k < gseq.size(); k++) chk("alt_grant_order", 64'(gseq[k]), 64'(k % 2));
      drain();

      // Result held for 10 cycles with resp_ready low.
      resp_ready = '0;
      new_ops(0); new_ops(1);
      req_valid = 3'b011;
      to_neg();
      g = 0;
      for (int i = 0; i < NREQ; i++) if (acc_mask[i]) g = i;
      other = (g == 0) ? 1 : 0;
      to_drive();
      req_valid[g] = 1'b0;
      to_neg();
      to_drive();
      for (int c = 0; c < 10; c++) begin
         to_neg();
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         chk("hold_resp_valid", 64'(resp_valid), 64'(1 << g));
         to_drive();
      end
      resp_ready = '1;
      to_neg();
      chk("release_resp_valid", 64'(resp_valid), 64'(1 << g));
      to_drive();
      to_neg();
      chk("regrant_after_hs", 64'(req_ready), 64'(1 << other));
      to_drive();
      req_valid = req_valid & ~acc_mask;
      drain();

      // Reset during ISSUE while serving requester 1.
      issue_one(0, 4'd0, 64'd1, 64'd2, 64'd3, 1'b0);
      new_ops(1);
      req_valid = 3'b010;
      to_neg();
      chk("pre_rst_grant1", 64'(req_ready), 64'b010);
      to_drive();
      new_ops(0); new_ops(2);
      req_valid = 3'b101;
      assert_rst_mid_cycle();
      to_neg();
      to_drive();
      rst = 1'b0;
      to_neg();
      chk("post_issue_rst_grant0", 64'(req_ready), 64'b001);
      to_drive();
      req_valid = 3'b100 & req_valid;
      req_valid[2] = 1'b0;
      drain();

      // Reset during RESP while serving requester 1.
      issue_one(0, 4'd2, 64'hF0, 64'h3C, 64'h30, 1'b0);
      new_ops(1);
      req_valid = 3'b010;
      resp_ready = '0;
      to_neg();
      to_drive();
      req_valid = '0;
      to_neg();
      to_drive();
      to_neg();
      chk("pre_rst_resp1", 64'(resp_valid), 64'b010);
      to_drive();
      new_ops(0); new_ops(2);
      req_valid = 3'b101;
      assert_rst_mid_cycle();
      to_neg();
      to_drive();
      rst = 1'b0;
      to_neg();
      chk("post_resp_rst_grant0", 64'(req_ready), 64'b001);
      to_drive();
      req_valid = req_valid & ~acc_mask;
      drain();

      // Randomized traffic with occasional asynchronous reset pulses.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         to_neg();
         to_drive();
         for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               new_ops(i);
            end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               new_ops(i);
            end
         end
         for (int i = 0; i < NREQ; i++) resp_ready[i] = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            assert_rst_mid_cycle();
            to_neg();
            to_drive();
            rst = 1'b0;
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   // Overall time bound.
   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
